// File: rtl/fp_n.sv
// Runtime-programmable integer clock divider (N >= 2) with 50% duty for even and odd N.
// Define FP_N_PULSE_OUT_EN to add out_pulse, a one-cycle strobe in the cnt==0 cycle.
module fp_n #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic [CNT_W-1:0] cur_div,
`ifdef FP_N_PULSE_OUT_EN
    output logic             out_clk,
    output logic             out_pulse
`else
    output logic             out_clk
`endif
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] next_div;
    logic [CNT_W:0]   hi;
    logic             pend_v;
    logic             odd;
    logic             out_u;
    logic             out_d;
    logic             err_hold;
    logic             wrap;
    logic             load_ok;
    logic             load_bad;
    logic             apply;

    always_comb begin
        hi       = ({1'b0, cur_div} + (CNT_W+1)'(1)) >> 1;
        wrap     = (cnt == cur_div - ONE);
        load_ok  = div_load && (div_in >= TWO);
        load_bad = div_load && (div_in < TWO);
        apply    = wrap && (pend_v || load_ok);
        next_div = load_ok ? div_in : pending;
    end

    // A rejection that coincides with an apply is held one cycle so ack and err never overlap.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt      <= '0;
            out_u    <= 1'b0;
            cur_div  <= DEF_DIV;
            odd      <= DEF_DIV[0];
            pending  <= '0;
            pend_v   <= 1'b0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
            err_hold <= 1'b0;
        end else begin
            out_u <= ({1'b0, cnt} < hi);
            cnt   <= wrap ? '0 : cnt + ONE;
            if (apply) begin
                cur_div <= next_div;
                odd     <= next_div[0];
                pend_v  <= 1'b0;
            end else if (load_ok) begin
                pending <= div_in;
                pend_v  <= 1'b1;
            end
            div_ack  <= apply;
            div_err  <= (load_bad || err_hold) && !apply;
            err_hold <= (load_bad || err_hold) && apply;
        end
    end

    always_ff @(negedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            out_d <= 1'b0;
        end else begin
            out_d <= out_u;
        end
    end

    // odd only changes at the wrap edge, where out_u is already low, so the select cannot glitch.
    assign out_clk = odd ? (out_u & out_d) : out_u;

`ifdef FP_N_PULSE_OUT_EN
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            out_pulse <= 1'b0;
        end else begin
            out_pulse <= wrap;
        end
    end
`endif

endmodule

// File: tb/tb_fp_n.sv
// Self-checking bench for fp_n: handshake responses and out_clk periods are scoreboarded.
module tb_fp_n;

    logic       in_clk = 1'b0;
    logic       in_rst = 1'b0;
    logic [7:0] div_in = 8'd0;
    logic       div_load = 1'b0;
    logic       div_ack;
    logic       div_err;
    logic [7:0] cur_div;
    logic       out_clk;
`ifdef FP_N_PULSE_OUT_EN
    logic       out_pulse;
`endif

    fp_n #(.CNT_W(8), .DIV_DEFAULT(5)) dut (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .div_in   (div_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .cur_div  (cur_div),
`ifdef FP_N_PULSE_OUT_EN
        .out_clk  (out_clk),
        .out_pulse(out_pulse)
`else
        .out_clk  (out_clk)
`endif
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hc = 0;

    always @(posedge in_clk) cyc <= cyc + 1;

    // kind: 2 = ack ({ack,err}=10), 1 = err ({ack,err}=01); due < 0 means cycle not checked
    typedef struct { int kind; int div; int due; } hs_t;
    typedef struct { int period; int high; } per_t;
    hs_t  hs_q[$];
    per_t per_q[$];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] value, input int kind, input int exp_div,
                                 input int due_off);
        if (kind != 0) hs_q.push_back('{kind, exp_div, (due_off < 0) ? -1 : cyc + due_off});
        div_in   = value;
        div_load = 1'b1;
        @(posedge in_clk); #1;
        div_load = 1'b0;
    endtask

    task automatic wait_edge(input logic want_high, input string tag);
        logic prev;
        int   seen;
        prev = out_clk;
        seen = 0;
        for (int n = 0; n < 200 && seen == 0; n++) begin
            @(in_clk); #1;
            if (out_clk == want_high && prev != want_high) seen = 1;
            prev = out_clk;
        end
        checkOutput(tag, seen, 1);
    endtask

    // Periods are measured fall-to-fall in half cycles; sync to a fall first so no
    // measured period straddles a ratio change.
    task automatic expect_periods(input int count, input int period_half, input int high_half);
        wait_edge(1'b0, "sync_fall");
        #1;
        repeat (count) per_q.push_back('{period_half, high_half});
        for (int n = 0; n < 400 && per_q.size() > 0; n++) @(posedge in_clk);
        #2;
        checkOutput("period_drain", per_q.size(), 0);
    endtask

    task automatic wait_hs_drain();
        for (int n = 0; n < 100 && hs_q.size() > 0; n++) @(posedge in_clk);
        #2;
        checkOutput("hs_drain", hs_q.size(), 0);
    endtask

    task automatic check_first_rise(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 10 && out_clk == 1'b0; i++) begin
            @(in_clk); #1;
            n++;
        end
        checkOutput(tag, n, 2);
    endtask

    initial begin : hs_monitor
        hs_t e;
        forever begin
            @(posedge in_clk); #1;
            if (in_rst && (div_ack || div_err)) begin
                if (hs_q.size() == 0) begin
                    checkOutput("hs_unexpected", int'({div_ack, div_err}), 0);
                end else begin
                    e = hs_q.pop_front();
                    checkOutput("hs_kind", int'({div_ack, div_err}), e.kind);
                    if (e.kind == 2) checkOutput("hs_cur_div", int'(cur_div), e.div);
                    if (e.due >= 0) checkOutput("hs_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin : period_monitor
        int   last_rise;
        int   last_fall;
        logic prev;
        per_t e;
        last_rise = -1;
        last_fall = -1;
        prev = 1'b0;
        forever begin
            @(in_clk); #1;
            hc++;
            if (!in_rst) begin
                last_rise = -1;
                last_fall = -1;
                prev = out_clk;
            end else begin
                if (out_clk && !prev) last_rise = hc;
                if (!out_clk && prev) begin
                    if (last_fall >= 0 && last_rise > last_fall && per_q.size() > 0) begin
                        e = per_q.pop_front();
                        checkOutput("period", hc - last_fall, e.period);
                        checkOutput("high", hc - last_rise, e.high);
                    end
                    last_fall = hc;
                end
                prev = out_clk;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
`ifdef FP_N_PULSE_OUT_EN
        int pulses;
        int last;
`endif
        // Reset state
        in_rst = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        checkOutput("rst_out_clk", int'(out_clk), 0);
        checkOutput("rst_cur_div", int'(cur_div), 5);
        checkOutput("rst_ack", int'(div_ack), 0);
        checkOutput("rst_err", int'(div_err), 0);

        // Default ratio 5: first rise on the negedge following the first posedge
        @(negedge in_clk); #1;
        in_rst = 1'b1;
        check_first_rise("first_rise_edges");
        expect_periods(3, 10, 5);

        // Invalid ratios are rejected without touching the divider
        @(posedge in_clk); #1;
        applyStimulus(8'd1, 1, 0, 1);
        @(posedge in_clk); #1;
        @(posedge in_clk); #1;
        applyStimulus(8'd0, 1, 0, 1);
        wait_hs_drain();
        checkOutput("err_cur_div", int'(cur_div), 5);
        expect_periods(2, 10, 5);

        // Load 4 at cnt==1: current period finishes, ack one cycle after the wrap
        wait_edge(1'b1, "rise_n5");
        applyStimulus(8'd4, 2, 4, 4);
        wait_hs_drain();
        checkOutput("cur_div_4", int'(cur_div), 4);
        expect_periods(3, 8, 4);

        // Load 8 then 7 before the wrap: last wins, single ack
        wait_edge(1'b1, "rise_n4");
        applyStimulus(8'd8, 0, 0, 0);
        applyStimulus(8'd7, 2, 7, 2);
        wait_hs_drain();
        checkOutput("cur_div_7", int'(cur_div), 7);
        expect_periods(3, 14, 7);

        // Load 6 on the cnt==N-1 cycle: applied at that same wrap
        wait_edge(1'b0, "fall_n7");
        @(posedge in_clk); #1;
        applyStimulus(8'd6, 2, 6, 1);
        wait_hs_drain();
        checkOutput("cur_div_6", int'(cur_div), 6);
        expect_periods(2, 12, 6);

        // Asynchronous reset while out_clk is high
        wait_edge(1'b1, "rise_n6");
        #1;
        in_rst = 1'b0;
        #1;
        checkOutput("midrst_out_clk", int'(out_clk), 0);
        checkOutput("midrst_cur_div", int'(cur_div), 5);
        repeat (2) @(posedge in_clk);
        @(negedge in_clk); #1;
        in_rst = 1'b1;
        check_first_rise("first_rise_after_midrst");
        checkOutput("post_rst_cur_div", int'(cur_div), 5);
        expect_periods(2, 10, 5);

`ifdef FP_N_PULSE_OUT_EN
        // Ratio 3: out_pulse once every 3 cycles, in the cnt==0 cycle where out_clk stays low
        @(posedge in_clk); #1;
        applyStimulus(8'd3, 2, 3, -1);
        wait_hs_drain();
        expect_periods(2, 6, 3);
        pulses = 0;
        last = -1;
        for (int i = 0; i < 12; i++) begin
            @(posedge in_clk); #1;
            if (out_pulse) begin
                pulses++;
                if (last >= 0) checkOutput("pulse_gap", i - last, 3);
                last = i;
                @(negedge in_clk); #1;
                checkOutput("pulse_align", int'(out_clk), 0);
            end
        end
        checkOutput("pulse_count", pulses, 4);
`endif

        checkOutput("hs_leftover", hs_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
